// File: rtl/aes_pkg.sv
// Shared definitions for the AES serial front-end: state encoding, default
// geometry, and the derived serial frame lengths the wrappers also use.
package aes_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StBusy,
        StDone,
        StSend
    } state_e;

    localparam int unsigned NB_DEFAULT = 4;
    localparam int unsigned NK_DEFAULT = 4;

    localparam int unsigned LOAD_BITS = 32 * (NB_DEFAULT + NK_DEFAULT);
    localparam int unsigned SEND_BITS = 32 * NB_DEFAULT;

    function automatic int unsigned load_bits(input int unsigned nb, input int unsigned nk);
        return 32 * (nb + nk);
    endfunction

    function automatic int unsigned send_bits(input int unsigned nb);
        return 32 * nb;
    endfunction

endpackage

// File: rtl/aes_serial_responder.sv
// Device end of the single-bit host link: loads data+key LSB-first, runs the
// core through a start/done handshake and streams the result back on mosi.
module aes_serial_responder
    import aes_pkg::*;
#(
    parameter int unsigned Nb = NB_DEFAULT,
    parameter int unsigned Nk = NK_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                miso,
    output logic                mosi,
    output logic                finished,
    output logic                core_start,
    output logic [32*Nb-1:0]    core_data,
    output logic [32*Nk-1:0]    core_key,
    input  logic                core_done,
    input  logic [32*Nb-1:0]    core_result
);

    localparam int unsigned LoadBits = load_bits(Nb, Nk);
    localparam int unsigned SendBits = send_bits(Nb);
    localparam int unsigned IdxW     = $clog2(SendBits);
    localparam logic [8:0]  LoadEnd  = 9'(LoadBits);
    localparam logic [8:0]  SendEnd  = 9'(SendBits);

    state_e                 state_q;
    logic [8:0]             cnt_q;
    logic [LoadBits-1:0]    load_q;
    logic [SendBits-1:0]    result_q;

    logic [8:0]             cnt_inc;
    logic                   send_bit;
    logic [LoadBits-1:0]    load_mask;

    always_comb begin
        cnt_inc   = (cnt_q < SendEnd) ? cnt_q + 9'd1 : cnt_q;
        send_bit  = (cnt_inc < SendEnd) ? result_q[cnt_inc[IdxW-1:0]] : 1'b0;
        load_mask = {{(LoadBits-1){1'b0}}, miso} << cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            load_q     <= '0;
            result_q   <= '0;
            mosi       <= 1'b0;
            finished   <= 1'b0;
            core_start <= 1'b0;
            core_data  <= '0;
            core_key   <= '0;
        end else begin
            core_start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    mosi <= 1'b0;
                    // Entry edge is the host's dummy edge: nothing is sampled.
                    if (cs) begin
                        state_q <= StLoad;
                        cnt_q   <= '0;
                        load_q  <= '0;
                    end
                end
                StLoad: begin
                    if (cs) begin
                        if (cnt_q < LoadEnd) begin
                            load_q <= load_q | load_mask;
                            cnt_q  <= cnt_q + 9'd1;
                        end
                    end else if (cnt_q == LoadEnd) begin
                        state_q    <= StBusy;
                        core_start <= 1'b1;
                        core_data  <= load_q[SendBits-1:0];
                        core_key   <= load_q[LoadBits-1:SendBits];
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StBusy: begin
                    if (core_done) begin
                        result_q <= core_result;
                        finished <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    if (cs) begin
                        state_q  <= StSend;
                        cnt_q    <= '0;
                        finished <= 1'b0;
                        mosi     <= result_q[0];
                    end
                end
                StSend: begin
                    if (cs) begin
                        cnt_q <= cnt_inc;
                        mosi  <= send_bit;
                    end else begin
                        state_q <= StIdle;
                        mosi    <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_serial_responder.sv
// Directed bench for aes_serial_responder: Nk=4 and Nk=8 instances driven as a
// host would, with a hand-driven core reply and known AES vectors.
module tb_aes_serial_responder;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         cs4 = 1'b0, miso4 = 1'b0, done4 = 1'b0;
    logic [127:0] res4 = '0;
    logic         mosi4, fin4, start4;
    logic [127:0] data4, key4;

    logic         cs8 = 1'b0, miso8 = 1'b0, done8 = 1'b0;
    logic [127:0] res8 = '0;
    logic         mosi8, fin8, start8;
    logic [127:0] data8;
    logic [255:0] key8;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] D2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K8 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    always #5 clk = ~clk;

    aes_serial_responder #(.Nb(4), .Nk(4)) u4 (
        .clk(clk), .rst(rst), .cs(cs4), .miso(miso4), .mosi(mosi4),
        .finished(fin4), .core_start(start4), .core_data(data4), .core_key(key4),
        .core_done(done4), .core_result(res4)
    );

    aes_serial_responder #(.Nb(4), .Nk(8)) u8 (
        .clk(clk), .rst(rst), .cs(cs8), .miso(miso8), .mosi(mosi8),
        .finished(fin8), .core_start(start8), .core_data(data8), .core_key(key8),
        .core_done(done8), .core_result(res8)
    );

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Host load: dummy edge, then n bits LSB-first, extra junk bits, then cs low.
    task automatic do_load(input int sel, input logic [383:0] bits, input int n,
                           input int extra, input int spur);
        @(negedge clk);
        if (sel == 0) begin cs4 = 1'b1; miso4 = 1'b0; end
        else begin cs8 = 1'b1; miso8 = 1'b0; end
        for (int i = 0; i < n + extra; i++) begin
            @(negedge clk);
            if (sel == 0) begin
                miso4 = (i < n) ? bits[i] : 1'b1;
                done4 = (i == spur);
                if (i == spur + 1 && spur >= 0) begin
                    check("spur_load_state", 384'(u4.state_q), 384'(StLoad));
                    check("spur_load_fin", 384'(fin4), 384'(0));
                end
            end else begin
                miso8 = (i < n) ? bits[i] : 1'b1;
            end
        end
        @(negedge clk);
        if (sel == 0) begin cs4 = 1'b0; miso4 = 1'b0; done4 = 1'b0; end
        else begin cs8 = 1'b0; miso8 = 1'b0; end
    endtask

    task automatic core_reply(input logic [127:0] r);
        repeat (3) @(negedge clk);
        done4 = 1'b1;
        res4  = r;
        @(negedge clk);
        done4 = 1'b0;
        res4  = ~r;
        check("finished_rise", 384'(fin4), 384'(1));
    endtask

    // Host send window of ncap captured bits (from the negedge after each edge).
    task automatic do_send(input int ncap, output logic [127:0] cap);
        cap = '0;
        @(negedge clk);
        cs4 = 1'b1;
        for (int k = 0; k < ncap; k++) begin
            @(negedge clk);
            cap[k] = mosi4;
            if (k == 0) check("finished_fall", 384'(fin4), 384'(0));
        end
    endtask

    task automatic full_load_start(input logic [127:0] d, input logic [127:0] k, input string tag);
        do_load(0, {128'h0, k, d}, 256, 0, -1);
        @(negedge clk);
        check({tag, "_start"}, 384'(start4), 384'(1));
        check({tag, "_data"}, 384'(data4), 384'(d));
        check({tag, "_key"}, 384'(key4), 384'(k));
        @(negedge clk);
        check({tag, "_start_pulse"}, 384'(start4), 384'(0));
    endtask

    initial begin
        logic [127:0] cap;

        repeat (3) @(negedge clk);
        check("rst_mosi", 384'(mosi4), 384'(0));
        check("rst_fin", 384'(fin4), 384'(0));
        check("rst_start", 384'(start4), 384'(0));
        check("rst_data", 384'(data4), 384'(0));
        check("rst_key", 384'(key4), 384'(0));
        check("rst_state", 384'(u4.state_q), 384'(StIdle));
        rst = 1'b0;

        // Spurious done while idle.
        @(negedge clk);
        done4 = 1'b1;
        @(negedge clk);
        done4 = 1'b0;
        check("spur_idle_state", 384'(u4.state_q), 384'(StIdle));
        check("spur_idle_fin", 384'(fin4), 384'(0));

        // Full Nk=4 load with a spurious done in the middle of it.
        do_load(0, {128'h0, K1, D1}, 256, 0, 50);
        @(negedge clk);
        check("t1_start", 384'(start4), 384'(1));
        check("t1_data", 384'(data4), 384'(D1));
        check("t1_key", 384'(key4), 384'(K1));
        check("t1_busy", 384'(u4.state_q), 384'(StBusy));
        @(negedge clk);
        check("t1_start_pulse", 384'(start4), 384'(0));
        core_reply(R1);
        do_send(128, cap);
        @(negedge clk);
        check("t1_mosi_sat", 384'(mosi4), 384'(0));
        cs4 = 1'b0;
        check("t1_result", 384'(cap), 384'(R1));
        @(negedge clk);
        check("t1_idle", 384'(u4.state_q), 384'(StIdle));
        check("t1_mosi_idle", 384'(mosi4), 384'(0));

        // Short load: 100 bits then cs drops.
        do_load(0, {128'h0, K2, D2}, 100, 0, -1);
        @(negedge clk);
        check("short_start", 384'(start4), 384'(0));
        check("short_idle", 384'(u4.state_q), 384'(StIdle));
        check("short_data_kept", 384'(data4), 384'(D1));
        check("short_key_kept", 384'(key4), 384'(K1));

        full_load_start(D2, K2, "t2");
        core_reply(R2);
        do_send(128, cap);
        @(negedge clk);
        cs4 = 1'b0;
        check("t2_result", 384'(cap), 384'(R2));
        @(negedge clk);

        // Reset in the middle of a send window.
        full_load_start(D1, K1, "t3");
        core_reply(R1);
        do_send(60, cap);
        check("t3_partial", 384'(cap[59:0]), 384'(R1[59:0]));
        rst = 1'b1;
        @(negedge clk);
        check("rst_send_mosi", 384'(mosi4), 384'(0));
        check("rst_send_fin", 384'(fin4), 384'(0));
        check("rst_send_state", 384'(u4.state_q), 384'(StIdle));
        rst = 1'b0;
        cs4 = 1'b0;
        @(negedge clk);

        full_load_start(D2, K2, "t4");
        core_reply(R2);
        do_send(128, cap);
        @(negedge clk);
        cs4 = 1'b0;
        check("t4_result", 384'(cap), 384'(R2));

        // Nk=8: 384-bit frame plus 10 ignored bits.
        do_load(1, {K8, D1}, 384, 10, -1);
        @(negedge clk);
        check("k8_start", 384'(start8), 384'(1));
        check("k8_data", 384'(data8), 384'(D1));
        check("k8_key", 384'(key8), 384'(K8));
        @(negedge clk);
        check("k8_start_pulse", 384'(start8), 384'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
